// File: rtl/pal_seq_array_pkg.sv
// pal_pkg: frame geometry helpers, configuration FSM encoding and CRC-8 constants
// shared by the pal_seq_array fabric.
`default_nettype none

package pal_pkg;

  localparam logic [7:0] CRC8_POLY = 8'h07;
  localparam int         CRC_LEN   = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_CHECK = 2'd2
  } cfg_state_e;

  function automatic int cfg_bits(input int n, input int m, input int p);
    return 2 * (n + m) * p + p * m + 2 * m;
  endfunction

  // Macrocell control: bit 2m = registered, 2m+1 = invert.
  function automatic int mc_idx(input int m_i, input int inv);
    return 2 * m_i + inv;
  endfunction

  function automatic int or_idx(input int m, input int p_i, input int m_i);
    return 2 * m + p_i * m + m_i;
  endfunction

  function automatic int and_idx(input int n, input int m, input int p,
                                 input int p_i, input int l_i, input int comp);
    return 2 * m + p * m + 2 * (n + m) * p_i + 2 * l_i + comp;
  endfunction

  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
    return {crc[6:0], 1'b0} ^ ((crc[7] ^ b) ? CRC8_POLY : 8'h00);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pal_seq_array_if.sv
// pal_seq_array_if: pad-side bundle of the PAL fabric (inputs, outputs, serial config pins).
`default_nettype none

interface pal_seq_array_if #(
  parameter int N = 8,
  parameter int M = 6
);
  logic         cfg_en;
  logic         cfg_valid;
  logic         cfg_bit;
  logic [N-1:0] in_vals;
  logic [M-1:0] out_vals;
  logic         cfg_busy;
  logic         cfg_done;
  logic         cfg_err;
  logic         cfg_loaded;

  modport master (
    output cfg_en, cfg_valid, cfg_bit, in_vals,
    input  out_vals, cfg_busy, cfg_done, cfg_err, cfg_loaded
  );

  modport slave (
    input  cfg_en, cfg_valid, cfg_bit, in_vals,
    output out_vals, cfg_busy, cfg_done, cfg_err, cfg_loaded
  );
endinterface

`default_nettype wire

// File: rtl/pal_seq_array_macrocell.sv
// pal_macrocell: OR-reduces selected product terms, applies polarity, and picks
// combinational or registered output. Flop Q always feeds back to the AND plane.
`default_nettype none

module pal_macrocell #(
  parameter int P = 17
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         i_clear,
  input  wire logic [P-1:0] i_terms,
  input  wire logic [P-1:0] i_or_mask,
  input  wire logic         i_registered,
  input  wire logic         i_invert,
  output logic              o_out,
  output logic              o_q
);

  logic w_d;
  logic r_q;

  assign w_d = (|(i_terms & i_or_mask)) ^ i_invert;

  // The flop tracks d in both modes so feedback is always the registered value.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_q <= 1'b0;
    end else begin
      r_q <= w_d;
    end
  end

  assign o_q   = r_q;
  assign o_out = i_registered ? r_q : w_d;

endmodule

`default_nettype wire

// File: rtl/pal_seq_array.sv
// pal_seq_array: PAL fabric with feedback macrocells and double-buffered serial config.
// Optional macro PAL_CFG_CRC_EN appends a CRC-8 trailer that gates each commit.
`default_nettype none

module pal_seq_array
  import pal_pkg::*;
#(
  parameter int N = 8,
  parameter int M = 6,
  parameter int P = 17
) (
  input  wire logic         clk,
  input  wire logic         rst,
  pal_seq_array_if.slave    bus
);

  localparam int L        = N + M;
  localparam int CFG_BITS = cfg_bits(N, M, P);
`ifdef PAL_CFG_CRC_EN
  localparam int FRAME_LEN = CFG_BITS + CRC_LEN;
`else
  localparam int FRAME_LEN = CFG_BITS;
`endif
  localparam int CNT_W = $clog2(FRAME_LEN + 1);

  localparam logic [CNT_W-1:0] c_cfg_last   = CNT_W'(CFG_BITS - 1);
  localparam logic [CNT_W-1:0] c_frame_last = CNT_W'(FRAME_LEN - 1);

  cfg_state_e          r_state;
  cfg_state_e          w_state_nxt;
  logic [CNT_W-1:0]    r_count;
  logic [CFG_BITS-1:0] r_shadow;
  logic [CFG_BITS-1:0] r_active;
  logic [CFG_BITS-1:0] w_shadow_nxt;
  logic                r_done;
  logic                r_loaded;

  logic w_accept;
  logic w_abort;
  logic w_last;
  logic w_shift_cfg;
  logic w_commit;

  logic [M-1:0] w_q;
  logic [M-1:0] w_out;
  logic [L-1:0] w_lits;
  logic [P-1:0] w_terms;

  assign w_accept     = bus.cfg_en & bus.cfg_valid;
  assign w_shadow_nxt = {r_shadow[CFG_BITS-2:0], bus.cfg_bit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (!bus.cfg_en) begin
          w_state_nxt = ST_IDLE;
        end else if (w_accept && (r_count == c_cfg_last)) begin
`ifdef PAL_CFG_CRC_EN
          w_state_nxt = ST_CHECK;
`else
          w_state_nxt = ST_IDLE;
`endif
        end
      end
      ST_CHECK: begin
        if (!bus.cfg_en || (w_accept && (r_count == c_frame_last))) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef PAL_CFG_CRC_EN
  logic [7:0]         r_crc_calc;
  logic [CRC_LEN-2:0] r_crc_rx;
  logic               r_err;
  logic               w_crc_ok;
  logic               w_reject;
`endif

  always_comb begin
    w_abort     = (r_state != ST_IDLE) && !bus.cfg_en;
    w_last      = w_accept && (r_count == c_frame_last);
    w_shift_cfg = w_accept && (r_state != ST_CHECK);
`ifdef PAL_CFG_CRC_EN
    w_crc_ok    = (r_crc_calc == {r_crc_rx, bus.cfg_bit});
    w_commit    = w_last && w_crc_ok;
    w_reject    = w_last && !w_crc_ok;
`else
    w_commit    = w_last;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count  <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_done   <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      r_done <= w_commit;
      if (w_abort || w_last) begin
        r_count <= '0;
      end else if (w_accept) begin
        r_count <= r_count + 1'b1;
      end
      if (w_shift_cfg) r_shadow <= w_shadow_nxt;
      if (w_commit) begin
`ifdef PAL_CFG_CRC_EN
        r_active <= r_shadow;
`else
        r_active <= w_shadow_nxt;
`endif
        r_loaded <= 1'b1;
      end
    end
  end

`ifdef PAL_CFG_CRC_EN
  // Config bits feed the running CRC; trailer bits are collected for comparison.
  always_ff @(posedge clk) begin
    if (rst || w_abort || w_last) begin
      r_crc_calc <= '0;
      r_crc_rx   <= '0;
      r_err      <= 1'b0;
    end else begin
      r_err <= 1'b0;
      if (w_shift_cfg) r_crc_calc <= crc8_step(r_crc_calc, bus.cfg_bit);
      if (w_accept && (r_state == ST_CHECK)) r_crc_rx <= {r_crc_rx[CRC_LEN-3:0], bus.cfg_bit};
    end
    if (!rst && w_reject) r_err <= 1'b1;
  end
  assign bus.cfg_err = r_err;
`else
  assign bus.cfg_err = 1'b0;
`endif

  assign w_lits = {w_q, bus.in_vals};

  for (genvar gp = 0; gp < P; gp++) begin : g_term
    logic [L-1:0] w_sel_t;
    logic [L-1:0] w_sel_c;
    for (genvar gl = 0; gl < L; gl++) begin : g_lit
      assign w_sel_t[gl] = r_active[and_idx(N, M, P, gp, gl, 0)];
      assign w_sel_c[gl] = r_active[and_idx(N, M, P, gp, gl, 1)];
    end
    // An empty term is forced to 0 rather than the vacuous AND of 1.
    assign w_terms[gp] = (|(w_sel_t | w_sel_c))
                       & (&((~w_sel_t | w_lits) & (~w_sel_c | ~w_lits)));
  end

  for (genvar gm = 0; gm < M; gm++) begin : g_mc
    logic [P-1:0] w_or_mask;
    for (genvar gp = 0; gp < P; gp++) begin : g_or
      assign w_or_mask[gp] = r_active[or_idx(M, gp, gm)];
    end
    pal_macrocell #(.P(P)) u_mc (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (w_commit),
      .i_terms      (w_terms),
      .i_or_mask    (w_or_mask),
      .i_registered (r_active[mc_idx(gm, 0)]),
      .i_invert     (r_active[mc_idx(gm, 1)]),
      .o_out        (w_out[gm]),
      .o_q          (w_q[gm])
    );
  end

  assign bus.out_vals   = w_out;
  assign bus.cfg_busy   = (r_count != '0);
  assign bus.cfg_done   = r_done;
  assign bus.cfg_loaded = r_loaded;

endmodule

`default_nettype wire

// File: tb/tb_pal_seq_array.sv
// tb_pal_seq_array: directed scoreboard bench for pal_seq_array (default and PAL_CFG_CRC_EN builds).
`default_nettype none

module tb_pal_seq_array;

  localparam int N  = 8;
  localparam int M  = 6;
  localparam int P  = 17;
  localparam int L  = N + M;
  localparam int CB = 590;
  localparam int AB = 2 * M + P * M;
`ifdef PAL_CFG_CRC_EN
  localparam int FL = CB + 8;
`else
  localparam int FL = CB;
`endif

  typedef logic [CB-1:0] cfg_t;
  typedef logic [FL-1:0] frame_t;
  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;
  exp_t sb[$];

  pal_seq_array_if #(.N(N), .M(M)) bus ();

  pal_seq_array #(.N(N), .M(M), .P(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [M-1:0] model_a(input logic [N-1:0] v);
    return {5'b0, v[0] & ~v[1]};
  endfunction

  function automatic logic [M-1:0] model_b(input logic [N-1:0] v);
    return {3'b0, ~v[2], 1'b0, ~v[0]};
  endfunction

  function automatic frame_t mk(input cfg_t c);
`ifdef PAL_CFG_CRC_EN
    logic [7:0] crc;
    logic       fbk;
    crc = 8'h00;
    for (int i = CB - 1; i >= 0; i--) begin
      fbk = crc[7] ^ c[i];
      crc = {crc[6:0], 1'b0} ^ (fbk ? 8'h07 : 8'h00);
    end
    return {c, crc};
`else
    return c;
`endif
  endfunction

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] act);
    exp_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", act);
    end else begin
      e = sb.pop_front();
      assert (act === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, act, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bits(input frame_t f, input int hi, input int lo);
    for (int i = hi; i >= lo; i--) begin
      bus.cfg_en    = 1'b1;
      bus.cfg_valid = 1'b1;
      bus.cfg_bit   = f[i];
      tick();
    end
  endtask

  task automatic commit_frame(input frame_t f, input string tag);
    send_bits(f, FL - 1, 0);
    push({tag, "_done"}, 32'd1);   check(32'(bus.cfg_done));
    push({tag, "_loaded"}, 32'd1); check(32'(bus.cfg_loaded));
    push({tag, "_busy"}, 32'd0);   check(32'(bus.cfg_busy));
  endtask

  task automatic apply(input string tag, input logic [N-1:0] v, input logic [M-1:0] e);
    bus.in_vals = v;
    push(tag, 32'(e));
    #2;
    check(32'(bus.out_vals));
    tick();
  endtask

  cfg_t   ca, cb_, ct;
  frame_t fa, fb, ft, fbad;

  initial begin
    vectors     = 0;
    miscompares = 0;
    ca  = '0;
    ca[AB + 0]              = 1'b1;  // term0: in0
    ca[AB + 2*1 + 1]        = 1'b1;  // term0: ~in1
    ca[2*M + 0]             = 1'b1;  // term0 -> out0
    ca[AB + 2*L*2 + 6]      = 1'b1;  // term2: in3 & ~in3
    ca[AB + 2*L*2 + 7]      = 1'b1;
    ca[2*M + 2*M + 3]       = 1'b1;  // term2 -> out3
    ca[2*M + 3*M + 4]       = 1'b1;  // empty term3 -> out4
    cb_ = '0;
    cb_[AB + 1]             = 1'b1;  // term0: ~in0
    cb_[2*M + 0]            = 1'b1;
    cb_[AB + 2*L*1 + 4]     = 1'b1;  // term1: in2
    cb_[2*M + 1*M + 2]      = 1'b1;  // term1 -> out2
    cb_[2*2 + 1]            = 1'b1;  // out2 inverted
    ct  = '0;
    ct[AB + 2*(N+1) + 1]    = 1'b1;  // term0: ~fb1
    ct[2*M + 1]             = 1'b1;  // term0 -> out1
    ct[2*1]                 = 1'b1;  // out1 registered
    fa = mk(ca);
    fb = mk(cb_);
    ft = mk(ct);

    rst           = 1'b1;
    bus.cfg_en    = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_bit   = 1'b0;
    bus.in_vals   = 8'hFF;
    tick(); tick();
    rst = 1'b0;
    tick();
    push("rst_out", 32'd0);    check(32'(bus.out_vals));
    push("rst_loaded", 32'd0); check(32'(bus.cfg_loaded));
    push("rst_busy", 32'd0);   check(32'(bus.cfg_busy));
    push("rst_done", 32'd0);   check(32'(bus.cfg_done));
    push("rst_err", 32'd0);    check(32'(bus.cfg_err));

    // Frame A, combinational and-or function
    commit_frame(fa, "a");
    bus.cfg_valid = 1'b0;
    bus.cfg_en    = 1'b0;
    apply("a_in01", 8'h01, model_a(8'h01));
    push("a_done_low", 32'd0); check(32'(bus.cfg_done));
    apply("a_in03", 8'h03, model_a(8'h03));
    apply("a_in00", 8'h00, model_a(8'h00));
    apply("a_in05", 8'h05, model_a(8'h05));
    apply("a_inFF", 8'hFF, model_a(8'hFF));
    apply("a_in09", 8'h09, model_a(8'h09));

    // Registered feedback toggle
    bus.in_vals = 8'h00;
    commit_frame(ft, "t");
    bus.cfg_valid = 1'b0;
    bus.cfg_en    = 1'b0;
    for (int k = 0; k < 4; k++) begin
      push("toggle", (k % 2 == 1) ? 32'h2 : 32'h0);
      check(32'(bus.out_vals));
      tick();
    end

    // Abort partial frame B, then load B while A keeps running
    commit_frame(fa, "a2");
    bus.in_vals = 8'h01;
    send_bits(fb, FL - 1, FL - 100);
    push("abort_busy_pre", 32'd1);     check(32'(bus.cfg_busy));
    push("abort_out_pre", 32'(model_a(8'h01))); check(32'(bus.out_vals));
    bus.cfg_en    = 1'b0;
    bus.cfg_valid = 1'b1;
    tick();
    bus.cfg_valid = 1'b0;
    push("abort_busy", 32'd0);   check(32'(bus.cfg_busy));
    push("abort_done", 32'd0);   check(32'(bus.cfg_done));
    push("abort_out", 32'(model_a(8'h01))); check(32'(bus.out_vals));
    send_bits(fb, FL - 1, 1);
    push("b_pre_done", 32'd0);   check(32'(bus.cfg_done));
    push("b_pre_out", 32'(model_a(8'h01))); check(32'(bus.out_vals));
    send_bits(fb, 0, 0);
    push("b_done", 32'd1);       check(32'(bus.cfg_done));
    push("b_out01", 32'(model_b(8'h01))); check(32'(bus.out_vals));
    bus.in_vals = 8'h00;
    #1;
    push("b_out00", 32'(model_b(8'h00))); check(32'(bus.out_vals));
    bus.in_vals = 8'h04;
    #1;
    push("b_out04", 32'(model_b(8'h04))); check(32'(bus.out_vals));

    // Back-to-back: next frame starts the cycle after commit
    bus.in_vals = 8'h01;
    commit_frame(fa, "b2b");
    bus.cfg_valid = 1'b0;
    bus.cfg_en    = 1'b0;
    apply("b2b_in01", 8'h01, model_a(8'h01));
    apply("b2b_in00", 8'h00, model_a(8'h00));

`ifdef PAL_CFG_CRC_EN
    fbad = fb;
    fbad[FL - 1 - 3] = ~fbad[FL - 1 - 3];
    bus.in_vals = 8'h01;
    send_bits(fbad, FL - 1, 0);
    bus.cfg_valid = 1'b0;
    bus.cfg_en    = 1'b0;
    push("crc_err", 32'd1);     check(32'(bus.cfg_err));
    push("crc_done", 32'd0);    check(32'(bus.cfg_done));
    push("crc_loaded", 32'd1);  check(32'(bus.cfg_loaded));
    push("crc_out", 32'(model_a(8'h01))); check(32'(bus.out_vals));
    tick();
    push("crc_err_low", 32'd0); check(32'(bus.cfg_err));
`else
    fbad = '0;
    push("err_tied", 32'd0);    check(32'(bus.cfg_err | fbad[0]));
`endif

    // Mid-frame reset clears everything including the active config
    send_bits(fb, FL - 1, FL - 20);
    rst = 1'b1;
    bus.cfg_valid = 1'b0;
    bus.cfg_en    = 1'b0;
    tick();
    rst = 1'b0;
    bus.in_vals = 8'h01;
    #1;
    push("rst2_out", 32'd0);    check(32'(bus.out_vals));
    push("rst2_loaded", 32'd0); check(32'(bus.cfg_loaded));
    push("rst2_busy", 32'd0);   check(32'(bus.cfg_busy));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pal_seq_array.md
# pal_seq_array

Parametrised next-generation PAL fabric with registered macrocells, output feedback into the AND plane and double-buffered serial configuration. A shadow chain is loaded bit-serially while the active configuration keeps evaluating. A complete frame is committed atomically. Sits directly behind the chip top wrapper: pads feed `in_vals` and the config pins; `out_vals` drives dedicated outputs.

## Interface
- `N`, 8, number of external input variables
- `M`, 6, number of outputs / macrocells
- `P`, 17, number of product terms
- derived `L = N+M` literals per term; `CFG_BITS = 2*L*P + P*M + 2*M` (default 590)
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  reset, synchronous, active-high
- `cfg_en`  in  1  frame window; low aborts any partial frame
- `cfg_valid`  in  1  qualifies `cfg_bit` this cycle
- `cfg_bit`  in  1  serial configuration data, first bit = frame MSB
- `in_vals`  in  N  external input variables
- `out_vals`  out  M  macrocell outputs
- `cfg_busy`  out  1  partial frame in shadow (bit count ≠ 0)
- `cfg_done`  out  1  one-cycle pulse: frame committed
- `cfg_err`  out  1  one-cycle pulse: frame rejected (CRC build only)
- `cfg_loaded`  out  1  level: active config valid since last reset

## Operation
- Frame layout (bit index in committed word): macrocell m: bit `2m` = registered, `2m+1` = invert; OR plane: bit `2M + p*M + m` connects term p to output m; AND plane base `A = 2M + P*M`: term p literal l true at `A + 2*L*p + 2l`, complement at `+1`.
- Literals 0..N-1 = `in_vals`; literals N..N+M-1 = macrocell register outputs (feedback, always the flop Q, even in combinational mode).
- Product term with no literal selected evaluates 0; term with both polarities of a literal evaluates 0 naturally.
- Macrocell: `sum = OR of connected terms`; `d = sum ^ invert`; comb mode: `out = d`; registered mode: `out = q`, `q <= d` every cycle.
- Config FSM states: IDLE (count 0), SHIFT, CHECK (CRC build only). Each cycle with `cfg_en & cfg_valid`: shadow shifts left, `cfg_bit` into LSB, count++. IDLE→SHIFT on first accepted bit.
- On accepting bit number FRAME_LEN (CFG_BITS, or CFG_BITS+8 with CRC): commit shadow→active (or reject), count←0, →IDLE.
- `cfg_en` low in SHIFT: count←0, →IDLE, shadow contents discarded, active untouched, no pulse.
- Bit accepted in the same cycle `cfg_en` is sampled high counts even if `cfg_en` drops next cycle.
- On commit: all macrocell flops cleared to 0 in the same edge; `cfg_loaded`←1.

## Timing
- Reset: active config all 0, flops 0, count 0, IDLE; `out_vals=0`, `cfg_busy=0`, `cfg_done=0`, `cfg_err=0`, `cfg_loaded=0`.
- Comb outputs: zero latency from `in_vals` (purely combinational path).
- Registered outputs: one cycle from `in_vals` to `out_vals`.
- Final bit accepted at edge k: new active config and `cfg_done=1` visible after edge k; `cfg_done` low after edge k+1.
- Minimum frame time FRAME_LEN cycles; back-to-back frames allowed (next bit accepted the cycle after commit).
- `rst` mid-frame: full reset including active config.

## Configuration
- `PAL_CFG_CRC_EN` defined: frame carries 8 trailing CRC bits (CRC-8, poly 0x07, init 0x00, computed over the CFG_BITS config bits in shift order, sent MSB first); on mismatch `cfg_err` pulses, active unchanged, `cfg_loaded` unchanged.
- Undefined: FRAME_LEN = CFG_BITS, every complete frame commits, `cfg_err` tied 0.

## Structure
- `pal_pkg`: CFG_BITS/offset functions (`and_idx`, `or_idx`, `mc_idx`), FSM state enum, CRC-8 poly constant.
- One sub-module `pal_macrocell` (OR reduce, invert, flop, mode mux), instantiated M times.
- Top holds shadow/active registers, counter, FSM, AND plane.

## Test plan
- Reset, no frame: `in_vals=8'hFF` → `out_vals=0`, `cfg_loaded=0`.
- Frame: term0 = in0 & ~in1, OR→out0, comb → `in_vals=8'h01` gives out0=1; `8'h03` gives 0; `cfg_done` one pulse on the cycle after the 590th bit.
- Toggle: term0 = ~fb(out1), out1 registered → out1 sequence 0,1,0,1 on successive cycles after commit.
- Abort: load frame A, start frame B, drop `cfg_en` after 100 bits → outputs still follow A, `cfg_busy` 0, then full frame B commits normally.
- Shift while running: during frame B loading, out0 keeps A's function until commit edge, then switches exactly on that edge.
- CRC build: correct trailer → `cfg_done`; single flipped config bit → `cfg_err` pulse, active config unchanged.
